// File: rtl/fir_session_ctrl_if.sv
// Signal bundle between the host/DMA streams, the FIR datapath and fir_session_ctrl.
// master is the controller side; slave is the environment (streams plus filter).
interface fir_session_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CNT_WIDTH  = 16
);
   logic                      start;
   logic [CNT_WIDTH-1:0]      numSamples;
   logic                      abort;
   logic                      coeffValid;
   logic [DATA_WIDTH-1:0]     coeffData;
   logic                      coeffReady;
   logic                      sampleValid;
   logic [DATA_WIDTH-1:0]     sampleData;
   logic                      sampleReady;
   logic                      firLoadCoeff;
   logic [DATA_WIDTH-1:0]     firCoeffIn;
   logic                      firLoadDataFlag;
   logic [DATA_WIDTH-1:0]     firDataIn;
   logic                      firStopDataLoadFlag;
   logic [3*DATA_WIDTH-1:0]   firDataOut;
   logic                      resultValid;
   logic [3*DATA_WIDTH-1:0]   resultData;
   logic                      busy;
   logic                      done;

   modport master (
      input  start, numSamples, abort, coeffValid, coeffData, sampleValid, sampleData, firDataOut,
      output coeffReady, sampleReady, firLoadCoeff, firCoeffIn, firLoadDataFlag, firDataIn,
             firStopDataLoadFlag, resultValid, resultData, busy, done
   );

   modport slave (
      output start, numSamples, abort, coeffValid, coeffData, sampleValid, sampleData, firDataOut,
      input  coeffReady, sampleReady, firLoadCoeff, firCoeffIn, firLoadDataFlag, firDataIn,
             firStopDataLoadFlag, resultValid, resultData, busy, done
   );
endinterface

// File: rtl/fir_session_ctrl.sv
// Session sequencer for one n-tap FIR: coefficient capture, coefficient burst,
// sample streaming, flush, stop and drain, with a registered result stream.
module fir_session_ctrl #(
   parameter int unsigned LENGTH     = 20,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic               clock,
   input  logic               reset,
   fir_session_ctrl_if.master bus
);
   localparam int unsigned RES_W = 3 * DATA_WIDTH;
   localparam int unsigned PH_W  = $clog2(LENGTH + 2);
   localparam int unsigned IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_BURST = 3'd2,
      S_RUN   = 3'd3,
      S_FLUSH = 3'd4,
      S_STOP  = 3'd5,
      S_DRAIN = 3'd6
   } state_e;

   state_e                state_q, state_d;
   logic [PH_W-1:0]       ph_q, ph_d;
   logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
   logic                  unlimited_q, unlimited_d;
   logic                  abort_q, abort_d;
   logic [DATA_WIDTH-1:0] store_q [LENGTH];

   logic                  load_coeff_q, load_coeff_d;
   logic [DATA_WIDTH-1:0] coeff_in_q, coeff_in_d;
   logic                  load_data_q, load_data_d;
   logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
   logic                  stop_q, stop_d;
   logic                  res_valid_q, res_valid_d;
   logic [RES_W-1:0]      res_data_q, res_data_d;
   logic                  done_q, done_d;

   logic                  coeff_ready_c, sample_ready_c;
   logic                  coeff_fire, sample_fire;
   logic [IDX_W-1:0]      rd_idx;

   assign coeff_ready_c  = (state_q == S_FILL);
   assign sample_ready_c = (state_q == S_RUN) && (unlimited_q || (remaining_q != '0));
   assign coeff_fire     = bus.coeffValid && coeff_ready_c;
   assign sample_fire    = bus.sampleValid && sample_ready_c;
   assign rd_idx         = IDX_W'(ph_d - PH_W'(1));

   // State register and all registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         ph_q         <= '0;
         remaining_q  <= '0;
         unlimited_q  <= 1'b0;
         abort_q      <= 1'b0;
         for (int i = 0; i < int'(LENGTH); i++) store_q[i] <= '0;
         load_coeff_q <= 1'b0;
         coeff_in_q   <= '0;
         load_data_q  <= 1'b0;
         data_in_q    <= '0;
         stop_q       <= 1'b0;
         res_valid_q  <= 1'b0;
         res_data_q   <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         ph_q         <= ph_d;
         remaining_q  <= remaining_d;
         unlimited_q  <= unlimited_d;
         abort_q      <= abort_d;
         if (coeff_fire) store_q[ph_q[IDX_W-1:0]] <= bus.coeffData;
         load_coeff_q <= load_coeff_d;
         coeff_in_q   <= coeff_in_d;
         load_data_q  <= load_data_d;
         data_in_q    <= data_in_d;
         stop_q       <= stop_d;
         res_valid_q  <= res_valid_d;
         res_data_q   <= res_data_d;
         done_q       <= done_d;
      end
   end

   // Next-state logic; ph_q counts coefficients in FILL and cycles in BURST/FLUSH/DRAIN.
   always_comb begin
      state_d     = state_q;
      ph_d        = ph_q;
      remaining_d = remaining_q;
      unlimited_d = unlimited_q;
      abort_d     = abort_q;
      case (state_q)
         S_IDLE: begin
            abort_d = 1'b0;
            ph_d    = '0;
            if (bus.start) begin
               state_d     = S_FILL;
               remaining_d = bus.numSamples;
               unlimited_d = (bus.numSamples == '0);
            end
         end
         S_FILL: begin
            if (bus.abort) begin
               state_d = S_STOP;
               ph_d    = '0;
            end else if (coeff_fire) begin
               if (ph_q == PH_W'(LENGTH - 1)) begin
                  state_d = S_BURST;
                  ph_d    = '0;
               end else begin
                  ph_d = ph_q + PH_W'(1);
               end
            end
         end
         S_BURST: begin
            // An abort here is held until the burst ends so the filter never sees a partial load.
            if (bus.abort) abort_d = 1'b1;
            if (ph_q == PH_W'(LENGTH + 1)) begin
               ph_d    = '0;
               state_d = (abort_q || bus.abort) ? S_FLUSH : S_RUN;
            end else begin
               ph_d = ph_q + PH_W'(1);
            end
         end
         S_RUN: begin
            if (sample_fire && !unlimited_q) remaining_d = remaining_q - CNT_WIDTH'(1);
            if (bus.abort || (sample_fire && !unlimited_q && (remaining_q == CNT_WIDTH'(1)))) begin
               state_d = S_FLUSH;
               ph_d    = '0;
            end
         end
         S_FLUSH: begin
            if (ph_q == PH_W'(1)) begin
               state_d = S_STOP;
               ph_d    = '0;
            end else begin
               ph_d = ph_q + PH_W'(1);
            end
         end
         S_STOP: begin
            state_d = S_DRAIN;
            ph_d    = '0;
         end
         S_DRAIN: begin
            if (ph_q == PH_W'(1)) begin
               state_d = S_IDLE;
               ph_d    = '0;
            end else begin
               ph_d = ph_q + PH_W'(1);
            end
         end
         default: begin
            state_d     = S_IDLE;
            ph_d        = '0;
            remaining_d = '0;
            unlimited_d = 1'b0;
            abort_d     = 1'b0;
         end
      endcase
   end

   // Output values for the next cycle, decoded from the next state so they line up with it.
   always_comb begin
      load_coeff_d = 1'b0;
      coeff_in_d   = '0;
      load_data_d  = 1'b0;
      data_in_d    = data_in_q;
      stop_d       = 1'b0;
      done_d       = 1'b0;
      res_valid_d  = load_data_q;
      res_data_d   = load_data_q ? bus.firDataOut : res_data_q;
      if (sample_fire) begin
         load_data_d = 1'b1;
         data_in_d   = bus.sampleData;
      end
      case (state_d)
         S_BURST: begin
            data_in_d    = '0;
            load_coeff_d = (ph_d == '0);
            if ((ph_d != '0) && (ph_d <= PH_W'(LENGTH))) coeff_in_d = store_q[rd_idx];
         end
         S_RUN, S_FLUSH: ;
         S_STOP:  stop_d    = 1'b1;
         default: data_in_d = '0;
      endcase
      if ((state_q == S_DRAIN) && (state_d == S_IDLE)) done_d = 1'b1;
   end

   assign bus.coeffReady          = coeff_ready_c;
   assign bus.sampleReady         = sample_ready_c;
   assign bus.firLoadCoeff        = load_coeff_q;
   assign bus.firCoeffIn          = coeff_in_q;
   assign bus.firLoadDataFlag     = load_data_q;
   assign bus.firDataIn           = data_in_q;
   assign bus.firStopDataLoadFlag = stop_q;
   assign bus.resultValid         = res_valid_q;
   assign bus.resultData          = res_data_q;
   assign bus.busy                = (state_q != S_IDLE);
   assign bus.done                = done_q;
endmodule

// File: tb/tb_fir_session_ctrl.sv
// Self-checking bench for fir_session_ctrl: randomized streams checked against
// a transaction-level model of the session (accepted samples, burst contents, pulse counts).
module tb_fir_session_ctrl;
   localparam int unsigned LEN = 4;
   localparam int unsigned DW  = 8;
   localparam int unsigned CW  = 16;
   localparam int unsigned RW  = 3 * DW;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   fir_session_ctrl_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
   fir_session_ctrl #(.LENGTH(LEN), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clock(clock), .reset(reset), .bus(bus));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int lc_cnt, stop_cnt, done_cnt, sr_cnt;
   logic [DW-1:0] flag_data [$];
   int            flag_cyc  [$];
   logic [RW-1:0] flag_fout [$];
   logic [RW-1:0] res_data  [$];
   int            res_cyc   [$];
   logic [DW-1:0] exp_samp  [$];
   int            exp_cyc   [$];
   logic [DW-1:0] coef [LEN];

   // Observer 1ns after each edge; also plays the filter by driving a fresh firDataOut every cycle.
   always @(posedge clock) begin
      #1;
      cyc++;
      bus.firDataOut = RW'({$urandom, $urandom});
      if (!reset) begin
         if (bus.firLoadDataFlag) begin
            flag_data.push_back(bus.firDataIn);
            flag_cyc.push_back(cyc);
            flag_fout.push_back(bus.firDataOut);
         end
         if (bus.resultValid) begin
            res_data.push_back(bus.resultData);
            res_cyc.push_back(cyc);
         end
         if (bus.firLoadCoeff) lc_cnt++;
         if (bus.firStopDataLoadFlag) stop_cnt++;
         if (bus.done) done_cnt++;
         if (bus.sampleReady) sr_cnt++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   function automatic logic [47:0] all_outs();
      return {bus.firLoadCoeff, bus.firCoeffIn, bus.firLoadDataFlag, bus.firDataIn,
              bus.firStopDataLoadFlag, bus.resultValid, bus.resultData, bus.busy, bus.done,
              bus.coeffReady, bus.sampleReady};
   endfunction

   task automatic idle_inputs();
      bus.start = 1'b0; bus.numSamples = '0; bus.abort = 1'b0;
      bus.coeffValid = 1'b0; bus.coeffData = '0;
      bus.sampleValid = 1'b0; bus.sampleData = '0;
   endtask

   task automatic clear_logs();
      lc_cnt = 0; stop_cnt = 0; done_cnt = 0; sr_cnt = 0;
      flag_data.delete(); flag_cyc.delete(); flag_fout.delete();
      res_data.delete(); res_cyc.delete(); exp_samp.delete(); exp_cyc.delete();
   endtask

   task automatic random_coefs();
      for (int i = 0; i < int'(LEN); i++) coef[i] = DW'($urandom);
   endtask

   task automatic start_session(input int n);
      @(negedge clock);
      bus.start = 1'b1; bus.numSamples = CW'(n);
      @(negedge clock);
      bus.start = 1'b0;
   endtask

   task automatic send_coeffs(input int n, input bit gaps);
      int i = 0;
      int guard = 0;
      while (i < n && guard < 200) begin
         @(negedge clock);
         guard++;
         if (gaps && ($urandom_range(0, 1) == 1)) begin
            bus.coeffValid = 1'b0;
            continue;
         end
         bus.coeffValid = 1'b1;
         bus.coeffData  = coef[i];
         #1;
         if (bus.coeffReady) i++;
      end
      total++;
      if (i != n) begin bad++; $display("FAIL coeff_accept got=%0d exp=%0d", i, n); end
   endtask

   // Walks the LENGTH+2 burst cycles; optionally raises abort during cycle abort_b.
   task automatic check_burst(input int abort_b);
      logic [DW-1:0] exp_ci;
      for (int b = 0; b <= int'(LEN) + 1; b++) begin
         @(posedge clock); #1;
         bus.coeffValid = 1'b0;
         exp_ci = (b >= 1 && b <= int'(LEN)) ? coef[b-1] : '0;
         total++;
         if (bus.firLoadCoeff !== (b == 0)) begin
            bad++; $display("FAIL burst_load_coeff b=%0d got=%b exp=%b", b, bus.firLoadCoeff, (b == 0));
         end
         total++;
         if (bus.firCoeffIn !== exp_ci) begin
            bad++; $display("FAIL burst_coeff_in b=%0d got=%h exp=%h", b, bus.firCoeffIn, exp_ci);
         end
         bus.abort = (b == abort_b);
      end
      bus.abort = 1'b0;
   endtask

   // mode 0: valid every cycle, 1: pattern 1,0,1,1, 2: random. Records each accepted sample.
   task automatic stream(input int n, input int mode, input bit abort_last, input bit fixed);
      int acc = 0;
      int k = 0;
      int guard = 0;
      logic v;
      while (acc < n && guard < 1000) begin
         @(negedge clock);
         guard++;
         case (mode)
            0:       v = 1'b1;
            1:       v = ((k % 4) != 1);
            default: v = ($urandom_range(0, 2) != 0);
         endcase
         k++;
         bus.sampleValid = v;
         bus.sampleData  = fixed ? ((acc == 0) ? DW'(1) : DW'(0)) : DW'($urandom);
         bus.abort       = abort_last && v && (acc == n - 1);
         #1;
         if (v && bus.sampleReady) begin
            exp_samp.push_back(bus.sampleData);
            exp_cyc.push_back(cyc);
            acc++;
         end
      end
      total++;
      if (acc != n) begin bad++; $display("FAIL sample_accept got=%0d exp=%0d", acc, n); end
   endtask

   task automatic wait_done(input string name, output int cycles);
      cycles = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock); #1;
         cycles++;
         if (bus.done) break;
      end
      total++;
      if (bus.done !== 1'b1) begin bad++; $display("FAIL %s_done_timeout got=%b exp=1", name, bus.done); end
      @(negedge clock);
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      total++;
      if (all_outs() !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", all_outs()); end
      reset = 1'b0;
      bus.abort = 1'b1;
      repeat (2) @(negedge clock);
      bus.abort = 1'b0;
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_abort_busy got=%b exp=0", bus.busy); end
   endtask

   task automatic test_session_scenario(input string name, input int n_req, input int n_acc,
                                        input int mode, input bit abort_last, input bit fixed);
      int cycles;
      clear_logs();
      start_session(n_req);
      total++;
      if (bus.busy !== 1'b1) begin bad++; $display("FAIL %s_busy_start got=%b exp=1", name, bus.busy); end
      bus.start = 1'b1;
      send_coeffs(int'(LEN), 1'b1);
      bus.start = 1'b0;
      check_burst(-1);
      stream(n_acc, mode, abort_last, fixed);
      @(posedge clock); #1;
      total++;
      if (bus.sampleReady !== 1'b0) begin
         bad++; $display("FAIL %s_ready_after_last got=%b exp=0", name, bus.sampleReady);
      end
      @(negedge clock);
      bus.sampleValid = 1'b0; bus.abort = 1'b0;
      wait_done(name, cycles);
      total++;
      if (flag_data.size() != n_acc) begin
         bad++; $display("FAIL %s_flag_count got=%0d exp=%0d", name, flag_data.size(), n_acc);
      end
      total++;
      if (res_data.size() != n_acc) begin
         bad++; $display("FAIL %s_result_count got=%0d exp=%0d", name, res_data.size(), n_acc);
      end
      for (int i = 0; i < n_acc && i < flag_data.size() && i < res_data.size(); i++) begin
         total++;
         if (flag_data[i] !== exp_samp[i]) begin
            bad++; $display("FAIL %s_data_in[%0d] got=%h exp=%h", name, i, flag_data[i], exp_samp[i]);
         end
         total++;
         if (flag_cyc[i] != exp_cyc[i] + 1) begin
            bad++; $display("FAIL %s_flag_latency[%0d] got=%0d exp=%0d", name, i, flag_cyc[i], exp_cyc[i] + 1);
         end
         total++;
         if (res_cyc[i] != flag_cyc[i] + 1) begin
            bad++; $display("FAIL %s_result_latency[%0d] got=%0d exp=%0d", name, i, res_cyc[i], flag_cyc[i] + 1);
         end
         total++;
         if (res_data[i] !== flag_fout[i]) begin
            bad++; $display("FAIL %s_result_data[%0d] got=%h exp=%h", name, i, res_data[i], flag_fout[i]);
         end
      end
      total++;
      if (lc_cnt != 1) begin bad++; $display("FAIL %s_load_coeff_pulses got=%0d exp=1", name, lc_cnt); end
      total++;
      if (stop_cnt != 1) begin bad++; $display("FAIL %s_stop_pulses got=%0d exp=1", name, stop_cnt); end
      total++;
      if (done_cnt != 1) begin bad++; $display("FAIL %s_done_pulses got=%0d exp=1", name, done_cnt); end
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL %s_end_busy got=%b exp=0", name, bus.busy); end
   endtask

   task automatic test_basic();
      for (int i = 0; i < int'(LEN); i++) coef[i] = DW'(i + 1);
      test_session_scenario("basic", 3, 3, 0, 1'b0, 1'b1);
   endtask

   task automatic test_backpressure();
      random_coefs();
      test_session_scenario("backpressure", 3, 3, 1, 1'b0, 1'b0);
   endtask

   task automatic test_abort_fill();
      int cycles = 0;
      random_coefs();
      clear_logs();
      start_session(3);
      send_coeffs(2, 1'b1);
      @(negedge clock);
      bus.coeffValid = 1'b0; bus.abort = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clock); #1;
         bus.abort = 1'b0;
         cycles++;
         if (bus.done) break;
      end
      @(negedge clock);
      total++;
      if (cycles != 4) begin bad++; $display("FAIL abort_fill_done_cycles got=%0d exp=4", cycles); end
      total++;
      if (lc_cnt != 0) begin bad++; $display("FAIL abort_fill_load_coeff got=%0d exp=0", lc_cnt); end
      total++;
      if (stop_cnt != 1) begin bad++; $display("FAIL abort_fill_stop_pulses got=%0d exp=1", stop_cnt); end
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_fill_end_busy got=%b exp=0", bus.busy); end
   endtask

   task automatic test_abort_burst();
      int cycles;
      random_coefs();
      clear_logs();
      start_session(5);
      send_coeffs(int'(LEN), 1'b0);
      bus.sampleValid = 1'b1; bus.sampleData = 8'h55;
      check_burst(2);
      wait_done("abort_burst", cycles);
      bus.sampleValid = 1'b0;
      total++;
      if (cycles != 6) begin bad++; $display("FAIL abort_burst_done_cycles got=%0d exp=6", cycles); end
      total++;
      if (flag_data.size() != 0) begin
         bad++; $display("FAIL abort_burst_flag_count got=%0d exp=0", flag_data.size());
      end
      total++;
      if (sr_cnt != 0) begin bad++; $display("FAIL abort_burst_sample_ready got=%0d exp=0", sr_cnt); end
      total++;
      if (stop_cnt != 1) begin bad++; $display("FAIL abort_burst_stop_pulses got=%0d exp=1", stop_cnt); end
   endtask

   task automatic test_reset_mid_run();
      random_coefs();
      clear_logs();
      start_session(10);
      send_coeffs(int'(LEN), 1'b0);
      check_burst(-1);
      stream(4, 0, 1'b0, 1'b0);
      @(posedge clock);
      @(negedge clock);
      #2;
      reset = 1'b1;
      #1;
      total++;
      if (all_outs() !== '0) begin bad++; $display("FAIL mid_run_reset_outputs got=%h exp=0", all_outs()); end
      @(negedge clock);
      idle_inputs();
      reset = 1'b0;
      random_coefs();
      test_session_scenario("after_reset", 3, 3, 2, 1'b0, 1'b0);
   endtask

   task automatic test_unlimited();
      random_coefs();
      test_session_scenario("unlimited", 0, 50, 2, 1'b1, 1'b0);
   endtask

   initial begin
      clear_logs();
      test_reset();
      test_basic();
      test_backpressure();
      test_abort_fill();
      test_abort_burst();
      test_reset_mid_run();
      test_unlimited();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
